// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, op encodings, mstatus fields, mcause codes.
// Optional counters are enabled by the CSR_COUNTERS_EN macro in csr_file.
package csr_pkg;

  typedef enum logic [11:0] {
    CSR_MVENDORID  = 12'hF11,
    CSR_MARCHID    = 12'hF12,
    CSR_MIMPID     = 12'hF13,
    CSR_MHARTID    = 12'hF14,
    CSR_MCONFIGPTR = 12'hF15,
    CSR_MSTATUS    = 12'h300,
    CSR_MTVEC      = 12'h305,
    CSR_MSCRATCH   = 12'h340,
    CSR_MEPC       = 12'h341,
    CSR_MCAUSE     = 12'h342,
    CSR_MTVAL      = 12'h343,
    CSR_MCYCLE     = 12'hB00,
    CSR_MINSTRET   = 12'hB02,
    CSR_MCYCLEH    = 12'hB80,
    CSR_MINSTRETH  = 12'hB82,
    CSR_CYCLE      = 12'hC00,
    CSR_INSTRET    = 12'hC02,
    CSR_CYCLEH     = 12'hC80,
    CSR_INSTRETH   = 12'hC82
  } csr_addr_e;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [31:0] {
    MCAUSE_INSN_MISALIGN  = 32'd0,
    MCAUSE_INSN_ACCESS    = 32'd1,
    MCAUSE_ILLEGAL_INSN   = 32'd2,
    MCAUSE_BREAKPOINT     = 32'd3,
    MCAUSE_LOAD_MISALIGN  = 32'd4,
    MCAUSE_LOAD_ACCESS    = 32'd5,
    MCAUSE_STORE_MISALIGN = 32'd6,
    MCAUSE_STORE_ACCESS   = 32'd7,
    MCAUSE_ECALL_M        = 32'd11
  } mcause_e;

  function automatic logic [31:0] csr_apply(
    input logic [1:0]  op,
    input logic [31:0] old,
    input logic [31:0] wd
  );
    case (op)
      CSR_OP_RS: csr_apply = old | wd;
      CSR_OP_RC: csr_apply = old & ~wd;
      default:   csr_apply = wd;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// csr_file_if: CSR access bus between EX/MEM and the CSR file.
// Master drives the request, slave returns old value and illegal flag.
interface csr_file_if;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic        csr_wen;
  logic        csr_ren;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (
    output csr_addr, csr_op, csr_wen, csr_ren, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_addr, csr_op, csr_wen, csr_ren, csr_wdata,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter with per-half write access.
// A write to either half replaces the increment for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);
  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i)
      cnt_d[31:0] = wdata_i;
    else if (wr_hi_i)
      cnt_d[63:32] = wdata_i;
    else if (inc_i)
      cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign lo_o = cnt_q[31:0];
  assign hi_o = cnt_q[63:32];
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with RMW ops, trap/MRET update, ID regs.
// CSR_COUNTERS_EN adds mcycle/minstret and their user read-only shadows.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] VENDOR_ID = 32'h0,
  parameter logic [31:0] ARCH_ID   = 32'h0,
  parameter logic [31:0] IMP_ID    = 32'h0,
  parameter logic [31:0] HART_ID   = 32'h0,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic        CLK,
  input  logic        RSTN,
  csr_file_if.slave   bus,
  input  logic        instr_retire,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);
  logic        mie_q, mpie_q;
  logic [31:2] mtvec_q, mepc_q;
  logic [31:0] mscratch_q, mcause_q, mtval_q;
  logic        mapped, ro, illegal, wr;
  logic [31:0] rval, wnew;
  logic [11:0] addr;
  logic        unused_pc;

  assign addr      = bus.csr_addr;
  assign unused_pc = ^trap_pc[1:0];

`ifdef CSR_COUNTERS_EN
  logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;

  csr_counter64 u_mcycle (
    .clk     (CLK),
    .rst_n   (RSTN),
    .inc_i   (1'b1),
    .wr_lo_i (wr && addr == CSR_MCYCLE),
    .wr_hi_i (wr && addr == CSR_MCYCLEH),
    .wdata_i (wnew),
    .lo_o    (cyc_lo),
    .hi_o    (cyc_hi)
  );

  csr_counter64 u_minstret (
    .clk     (CLK),
    .rst_n   (RSTN),
    .inc_i   (instr_retire),
    .wr_lo_i (wr && addr == CSR_MINSTRET),
    .wr_hi_i (wr && addr == CSR_MINSTRETH),
    .wdata_i (wnew),
    .lo_o    (ins_lo),
    .hi_o    (ins_hi)
  );
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

  always_comb begin
    mapped = 1'b1;
    ro     = 1'b0;
    rval   = '0;
    case (addr)
      CSR_MVENDORID:  begin rval = VENDOR_ID; ro = 1'b1; end
      CSR_MARCHID:    begin rval = ARCH_ID;   ro = 1'b1; end
      CSR_MIMPID:     begin rval = IMP_ID;    ro = 1'b1; end
      CSR_MHARTID:    begin rval = HART_ID;   ro = 1'b1; end
      CSR_MCONFIGPTR: ro = 1'b1;
      CSR_MSTATUS: begin
        rval[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        rval[MSTATUS_MIE]  = mie_q;
        rval[MSTATUS_MPIE] = mpie_q;
      end
      CSR_MTVEC:    rval = {mtvec_q, 2'b00};
      CSR_MSCRATCH: rval = mscratch_q;
      CSR_MEPC:     rval = {mepc_q, 2'b00};
      CSR_MCAUSE:   rval = mcause_q;
      CSR_MTVAL:    rval = mtval_q;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    rval = cyc_lo;
      CSR_MCYCLEH:   rval = cyc_hi;
      CSR_MINSTRET:  rval = ins_lo;
      CSR_MINSTRETH: rval = ins_hi;
      CSR_CYCLE:     begin rval = cyc_lo; ro = 1'b1; end
      CSR_CYCLEH:    begin rval = cyc_hi; ro = 1'b1; end
      CSR_INSTRET:   begin rval = ins_lo; ro = 1'b1; end
      CSR_INSTRETH:  begin rval = ins_hi; ro = 1'b1; end
`endif
      default: mapped = 1'b0;
    endcase
  end

  assign illegal = ((bus.csr_ren || bus.csr_wen) && !mapped)
                || (bus.csr_wen && bus.csr_op != CSR_OP_NONE && ro);
  assign wr      = bus.csr_wen && bus.csr_op != CSR_OP_NONE && !illegal;
  assign wnew    = csr_apply(bus.csr_op, rval, bus.csr_wdata);

  assign bus.csr_rdata   = (bus.csr_ren && mapped) ? rval : '0;
  assign bus.csr_illegal = illegal;

  // mtvec/mscratch are not touched by trap/MRET, so their writes always land
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST[31:2];
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      if (wr && addr == CSR_MTVEC)    mtvec_q    <= wnew[31:2];
      if (wr && addr == CSR_MSCRATCH) mscratch_q <= wnew;
      if (trap_valid) begin
        mepc_q   <= trap_pc[31:2];
        mcause_q <= trap_cause;
        mtval_q  <= trap_tval;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (mret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (wr) begin
        case (addr)
          CSR_MSTATUS: begin
            mie_q  <= wnew[MSTATUS_MIE];
            mpie_q <= wnew[MSTATUS_MPIE];
          end
          CSR_MEPC:   mepc_q   <= wnew[31:2];
          CSR_MCAUSE: mcause_q <= wnew;
          CSR_MTVAL:  mtval_q  <= wnew;
          default: ;
        endcase
      end
    end
  end

  assign mtvec_o = {mtvec_q, 2'b00};
  assign mepc_o  = {mepc_q, 2'b00};
  assign mie_o   = mie_q;
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: scoreboard bench for csr_file with a behavioural CSR model.
// Exercises directed cases, random traffic and a mid-run async reset.
module tb_csr_file;
  localparam logic [31:0] P_VEND = 32'h0000_0602;
  localparam logic [31:0] P_ARCH = 32'h0000_0011;
  localparam logic [31:0] P_IMP  = 32'h0000_0022;
  localparam logic [31:0] P_HART = 32'h0000_0005;
  localparam logic [31:0] P_TVEC = 32'h0000_0103;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        instr_retire = 1'b0;
  logic        trap_valid = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_tval = '0;
  logic [31:0] mtvec_o, mepc_o;
  logic        mie_o;

  always #5 CLK = ~CLK;

  csr_file_if bus();

  csr_file #(
    .VENDOR_ID (P_VEND),
    .ARCH_ID   (P_ARCH),
    .IMP_ID    (P_IMP),
    .HART_ID   (P_HART),
    .MTVEC_RST (P_TVEC)
  ) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .bus          (bus),
    .instr_retire (instr_retire),
    .trap_valid   (trap_valid),
    .trap_cause   (trap_cause),
    .trap_pc      (trap_pc),
    .trap_tval    (trap_tval),
    .mret         (mret),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .mie_o        (mie_o)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mie;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  bit [31:0] m_mtvec, m_scratch, m_mepc, m_cause, m_tval;
  bit        m_mie, m_mpie;
`ifdef CSR_COUNTERS_EN
  bit [63:0] m_cyc, m_ins;
`endif

  function automatic void model_reset();
    m_mtvec   = P_TVEC & 32'hFFFF_FFFC;
    m_scratch = 0;
    m_mepc    = 0;
    m_cause   = 0;
    m_tval    = 0;
    m_mie     = 0;
    m_mpie    = 0;
`ifdef CSR_COUNTERS_EN
    m_cyc = 0;
    m_ins = 0;
`endif
  endfunction

  function automatic void model_read(input logic [11:0] a,
                                     output bit mp, output bit ro,
                                     output logic [31:0] v);
    mp = 1; ro = 0; v = 0;
    case (a)
      12'hF11: begin v = P_VEND; ro = 1; end
      12'hF12: begin v = P_ARCH; ro = 1; end
      12'hF13: begin v = P_IMP;  ro = 1; end
      12'hF14: begin v = P_HART; ro = 1; end
      12'hF15: ro = 1;
      12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h305: v = m_mtvec;
      12'h340: v = m_scratch;
      12'h341: v = m_mepc;
      12'h342: v = m_cause;
      12'h343: v = m_tval;
`ifdef CSR_COUNTERS_EN
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
      12'hC00: begin v = m_cyc[31:0];  ro = 1; end
      12'hC80: begin v = m_cyc[63:32]; ro = 1; end
      12'hC02: begin v = m_ins[31:0];  ro = 1; end
      12'hC82: begin v = m_ins[63:32]; ro = 1; end
`endif
      default: mp = 0;
    endcase
  endfunction

  task automatic drive(input logic [11:0] a, input logic [1:0] op,
                       input logic wen, input logic ren,
                       input logic [31:0] wd,
                       input logic ret = 0, input logic trap = 0,
                       input logic [31:0] cause = 0,
                       input logic [31:0] pc = 0,
                       input logic [31:0] tval = 0,
                       input logic mr = 0, input logic rst = 1);
    bit mp, ro, ill, w;
    logic [31:0] v, nv;
    exp_t e;
    @(posedge CLK);
    #1;
    RSTN          = rst;
    bus.csr_addr  = a;
    bus.csr_op    = op;
    bus.csr_wen   = wen;
    bus.csr_ren   = ren;
    bus.csr_wdata = wd;
    instr_retire  = ret;
    trap_valid    = trap;
    trap_cause    = cause;
    trap_pc       = pc;
    trap_tval     = tval;
    mret          = mr;
    if (!rst) model_reset();
    model_read(a, mp, ro, v);
    ill     = ((ren || wen) && !mp) || (wen && op != 0 && ro);
    e.rdata = (ren && mp) ? v : 32'h0;
    e.ill   = ill;
    e.mtvec = m_mtvec;
    e.mepc  = m_mepc;
    e.mie   = m_mie;
    q.push_back(e);
    if (!rst) return;
    w  = wen && op != 0 && !ill;
    nv = (op == 2'b01) ? wd : (op == 2'b10) ? (v | wd) : (v & ~wd);
`ifdef CSR_COUNTERS_EN
    if (w && a == 12'hB00)      m_cyc[31:0]  = nv;
    else if (w && a == 12'hB80) m_cyc[63:32] = nv;
    else                        m_cyc        = m_cyc + 1;
    if (w && a == 12'hB02)      m_ins[31:0]  = nv;
    else if (w && a == 12'hB82) m_ins[63:32] = nv;
    else if (ret)               m_ins        = m_ins + 1;
`endif
    if (w && a == 12'h305) m_mtvec   = nv & 32'hFFFF_FFFC;
    if (w && a == 12'h340) m_scratch = nv;
    if (trap) begin
      m_mepc  = pc & 32'hFFFF_FFFC;
      m_cause = cause;
      m_tval  = tval;
      m_mpie  = m_mie;
      m_mie   = 0;
    end else if (mr) begin
      m_mie  = m_mpie;
      m_mpie = 1;
    end else if (w) begin
      case (a)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h341: m_mepc  = nv & 32'hFFFF_FFFC;
        12'h342: m_cause = nv;
        12'h343: m_tval  = nv;
        default: ;
      endcase
    end
  endtask

  task automatic idle(input logic rst = 1);
    drive(12'h000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, rst);
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rdata",   bus.csr_rdata,        e.rdata);
        chk("illegal", {31'b0, bus.csr_illegal}, {31'b0, e.ill});
        chk("mtvec_o", mtvec_o,              e.mtvec);
        chk("mepc_o",  mepc_o,               e.mepc);
        chk("mie_o",   {31'b0, mie_o},       {31'b0, e.mie});
      end
    end
  end

  logic [11:0] addrs [20] = '{
    12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hF15, 12'h300, 12'h305,
    12'h340, 12'h341, 12'h342, 12'h343, 12'hB00, 12'hB80, 12'hB02,
    12'hB82, 12'hC00, 12'hC02, 12'hC82, 12'h7C0, 12'h301
  };

  initial begin
    bus.csr_addr  = '0;
    bus.csr_op    = '0;
    bus.csr_wen   = 1'b0;
    bus.csr_ren   = 1'b0;
    bus.csr_wdata = '0;
    model_reset();
    idle(0);
    idle(0);
    idle(1);
    drive(12'h305, 2'b00, 0, 1, 0);
    drive(12'h300, 2'b00, 0, 1, 0);
    drive(12'h340, 2'b01, 1, 1, 32'hDEAD_BEEF);
    drive(12'h340, 2'b10, 1, 1, 32'h0000_0F00);
    drive(12'h340, 2'b00, 0, 1, 0);
    drive(12'h340, 2'b11, 1, 1, 32'hFFFF_0000);
    drive(12'h340, 2'b00, 0, 1, 0);
    drive(12'hF14, 2'b01, 1, 1, 32'h1234_5678);
    drive(12'hF14, 2'b00, 0, 1, 0);
    drive(12'h7C0, 2'b00, 0, 1, 0);
    drive(12'h300, 2'b10, 1, 1, 32'h8);
    drive(12'h341, 2'b01, 1, 1, 32'h4, 0, 1, 32'd11, 32'h1236, 32'h55);
    drive(12'h341, 2'b00, 0, 1, 0);
    drive(12'h342, 2'b00, 0, 1, 0);
    drive(12'h300, 2'b00, 0, 1, 0);
    drive(12'h300, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    drive(12'h300, 2'b00, 0, 1, 0);
    drive(12'h305, 2'b01, 1, 1, 32'h0000_0207);
    drive(12'h305, 2'b00, 0, 1, 0);
`ifdef CSR_COUNTERS_EN
    drive(12'hB00, 2'b01, 1, 0, 32'hFFFF_FFFF);
    idle();
    idle();
    drive(12'hB80, 2'b00, 0, 1, 0);
    drive(12'hB00, 2'b00, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(12'h000, 2'b00, 0, 0, 0, 1);
    drive(12'hC02, 2'b00, 0, 1, 0);
    drive(12'hC00, 2'b01, 1, 1, 32'h0);
`else
    drive(12'hB00, 2'b00, 0, 1, 0);
    drive(12'hC00, 2'b01, 1, 0, 32'h1);
`endif
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        idle(0);
      end else begin
        drive(addrs[$urandom_range(0, 19)], 2'($urandom),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
              $urandom, ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 19) == 0), $urandom, $urandom,
              $urandom, ($urandom_range(0, 19) == 0));
      end
    end
    idle();
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
